ibex_multdiv_iter: RTL and testbench

- Iterative (multi-cycle) multiply/divide unit for RV32M.
- Has no adder of its own. Every iteration it borrows the ALU's 33-bit adder: it drives the ALU's multdiv operand and enable inputs and consumes the ALU's 34-bit extended adder result.
- Sits in the EX stage beside the ALU. The decoder/controller holds request and operands stable until valid_o.

---
 rtl/ibex_multdiv_iter.sv | 239 +++++++++++++++++++++++
 tb/tb_ibex_multdiv_iter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M multiply/divide unit. It has no adder of its own: every
// working cycle it drives the ALU's multdiv operands and consumes the ALU's
// extended adder result. Multiply is shift-add (one partial product per
// cycle); divide is restoring division on magnitudes followed by a sign fix.
//
// Adder usage: operands are {value, carry_slot}. An add drives both carry
// slots 0; a subtract x - y drives {x,1} + {~y,1}, so the bit-0 column
// carries the +1 of the two's-complement negation into bit 1. The 32-bit
// result is ext[32:1] and the carry out is ext[33].
//
// Handshake: mult_en_i/div_en_i are levels held stable (with operator and
// operands) until valid_o; valid_o is a one-cycle pulse in FINISH and the
// result is only meaningful in that cycle. Dropping both enables in any
// working state aborts the operation without a valid_o.
module ibex_multdiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mult_en_i,
    input  logic            div_en_i,
    input  logic [1:0]      operator_i,
    input  logic [1:0]      signed_mode_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [XLEN+1:0] alu_adder_ext_i,
    output logic [XLEN:0]   alu_operand_a_o,
    output logic [XLEN:0]   alu_operand_b_o,
    output logic            multdiv_en_o,
    output logic            valid_o,
    output logic [XLEN-1:0] multdiv_result_o
);

    typedef enum logic [2:0] {
        IDLE, ABS_A, ABS_B, COMP, LAST, CHANGE_SIGN, FINISH
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    // acc: multiply high accumulator / divide partial remainder
    logic [XLEN-1:0] acc_q, acc_d;
    // a: multiplicand / dividend shifting out, quotient shifting in
    logic [XLEN-1:0] a_q, a_d;
    // b: multiplier shifting out, low product shifting in / divisor
    logic [XLEN-1:0] b_q, b_d;
    logic            is_mul_q, is_mul_d;
    logic            sel_hi_q, sel_hi_d;   // MULH or REM
    logic [1:0]      smode_q, smode_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;

    logic [XLEN-1:0] sum;
    logic            cout;
    logic            unused_ext0;
    logic [XLEN-1:0] pp;
    logic            mul_sub, acc_x, pp_x, mul_top;
    logic [XLEN-1:0] div_shift;
    logic            div_ge;
    logic [XLEN-1:0] cs_src;
    logic            cs_neg;
    logic            active;

    assign sum         = alu_adder_ext_i[XLEN:1];
    assign cout        = alu_adder_ext_i[XLEN+1];
    assign unused_ext0 = alu_adder_ext_i[0];
    assign active      = mult_en_i | div_en_i;

    // Multiply step. The accumulator is conceptually 33 bits; its top bit is
    // rebuilt from the operand extension bits and the adder carry out. The
    // final partial product of a signed multiplier has negative weight, so
    // LAST subtracts it instead of adding.
    assign pp      = b_q[0] ? a_q : '0;
    assign mul_sub = (state_q == LAST) & smode_q[1] & b_q[0];
    assign acc_x   = smode_q[0] & acc_q[XLEN-1];
    assign pp_x    = smode_q[0] & pp[XLEN-1];
    assign mul_top = acc_x ^ (pp_x ^ mul_sub) ^ cout;

    // Divide step. The shifted remainder is 33 bits; its top bit is the bit
    // shifted out of acc. The trial subtraction succeeds if that bit is set
    // or the 32-bit subtraction did not borrow.
    assign div_shift = {acc_q[XLEN-2:0], a_q[XLEN-1]};
    assign div_ge    = acc_q[XLEN-1] | cout;

    // Final sign fix: quotient takes sign(a)^sign(b), remainder takes sign(a).
    assign cs_src = sel_hi_q ? acc_q : a_q;
    assign cs_neg = sel_hi_q ? sign_a_q : (sign_a_q ^ sign_b_q);

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            is_mul_q <= 1'b0;
            sel_hi_q <= 1'b0;
            smode_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            is_mul_q <= is_mul_d;
            sel_hi_q <= sel_hi_d;
            smode_q  <= smode_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
        end
    end

    // Next-state, datapath updates and all outputs.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        acc_d            = acc_q;
        a_d              = a_q;
        b_d              = b_q;
        is_mul_d         = is_mul_q;
        sel_hi_d         = sel_hi_q;
        smode_d          = smode_q;
        sign_a_d         = sign_a_q;
        sign_b_d         = sign_b_q;
        alu_operand_a_o  = '0;
        alu_operand_b_o  = '0;
        multdiv_en_o     = 1'b0;
        valid_o          = 1'b0;
        multdiv_result_o = '0;

        case (state_q)
            IDLE: begin
                cnt_d = 5'd31;
                if (active) begin
                    is_mul_d = mult_en_i;
                    sel_hi_d = operator_i[0];
                    smode_d  = signed_mode_i;
                    sign_a_d = signed_mode_i[0] & op_a_i[XLEN-1];
                    sign_b_d = signed_mode_i[1] & op_b_i[XLEN-1];
                    acc_d    = '0;
                    a_d      = op_a_i;
                    b_d      = op_b_i;
                    if (mult_en_i) begin
                        state_d = COMP;
                    end else if (op_b_i == '0) begin
                        // Divide by zero: quotient all ones, remainder = a.
                        a_d     = '1;
                        acc_d   = op_a_i;
                        state_d = FINISH;
                    end else begin
                        state_d = ABS_A;
                    end
                end
            end
            ABS_A: begin
                multdiv_en_o = 1'b1;
                if (sign_a_q) begin
                    alu_operand_a_o = {{XLEN{1'b0}}, 1'b1};
                    alu_operand_b_o = {~a_q, 1'b1};
                end else begin
                    alu_operand_a_o = {a_q, 1'b0};
                end
                a_d     = sum;
                state_d = ABS_B;
            end
            ABS_B: begin
                multdiv_en_o = 1'b1;
                if (sign_b_q) begin
                    alu_operand_a_o = {{XLEN{1'b0}}, 1'b1};
                    alu_operand_b_o = {~b_q, 1'b1};
                end else begin
                    alu_operand_a_o = {b_q, 1'b0};
                end
                b_d     = sum;
                state_d = COMP;
            end
            COMP, LAST: begin
                multdiv_en_o = 1'b1;
                if (is_mul_q) begin
                    if (mul_sub) begin
                        alu_operand_a_o = {acc_q, 1'b1};
                        alu_operand_b_o = {~pp, 1'b1};
                    end else begin
                        alu_operand_a_o = {acc_q, 1'b0};
                        alu_operand_b_o = {pp, 1'b0};
                    end
                    acc_d = {mul_top, sum[XLEN-1:1]};
                    b_d   = {sum[0], b_q[XLEN-1:1]};
                end else begin
                    alu_operand_a_o = {div_shift, 1'b1};
                    alu_operand_b_o = {~b_q, 1'b1};
                    acc_d = div_ge ? sum : div_shift;
                    a_d   = {a_q[XLEN-2:0], div_ge};
                end
                if (state_q == COMP) begin
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = LAST;
                    end
                end else begin
                    state_d = is_mul_q ? FINISH : CHANGE_SIGN;
                end
            end
            CHANGE_SIGN: begin
                multdiv_en_o = 1'b1;
                if (cs_neg) begin
                    alu_operand_a_o = {{XLEN{1'b0}}, 1'b1};
                    alu_operand_b_o = {~cs_src, 1'b1};
                end else begin
                    alu_operand_a_o = {cs_src, 1'b0};
                end
                if (sel_hi_q) begin
                    acc_d = sum;
                end else begin
                    a_d = sum;
                end
                state_d = FINISH;
            end
            FINISH: begin
                valid_o = 1'b1;
                if (is_mul_q) begin
                    multdiv_result_o = sel_hi_q ? acc_q : b_q;
                end else begin
                    multdiv_result_o = sel_hi_q ? acc_q : a_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort: the controller withdrew the request mid-operation.
        if (!active && state_q != IDLE && state_q != FINISH) begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Bench for ibex_multdiv_iter: directed cases plus randomized operations,
// checked against a plain-arithmetic reference model through an expected
// queue that a separate monitor drains on every valid_o.
module tb_ibex_multdiv_iter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mult_en = 1'b0;
  logic        div_en = 1'b0;
  logic [1:0]  operator = '0;
  logic [1:0]  signed_mode = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [33:0] alu_adder_ext;
  logic [32:0] alu_operand_a;
  logic [32:0] alu_operand_b;
  logic        multdiv_en;
  logic        valid_o;
  logic [31:0] result;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  // ALU adder the unit borrows: a plain 33+33 -> 34 bit add.
  assign alu_adder_ext = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};

  ibex_multdiv_iter #(.XLEN(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mult_en_i        (mult_en),
    .div_en_i         (div_en),
    .operator_i       (operator),
    .signed_mode_i    (signed_mode),
    .op_a_i           (op_a),
    .op_b_i           (op_b),
    .alu_adder_ext_i  (alu_adder_ext),
    .alu_operand_a_o  (alu_operand_a),
    .alu_operand_b_o  (alu_operand_b),
    .multdiv_en_o     (multdiv_en),
    .valid_o          (valid_o),
    .multdiv_result_o (result)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event did not meet expectation (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic is_mul, input logic [1:0] op,
                                        input logic [1:0] sm, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] xa, xb, p;
    logic [31:0] q, r;
    int sq, sr;
    if (is_mul) begin
      xa = sm[0] ? {{32{a[31]}}, a} : {32'b0, a};
      xb = sm[1] ? {{32{b[31]}}, b} : {32'b0, b};
      p  = xa * xb;
      return op[0] ? p[63:32] : p[31:0];
    end
    if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
    if (sm == 2'b11) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'd0 : 32'h8000_0000;
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      q  = sq;
      r  = sr;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[0] ? r : q;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [31:0] e;
    int          ec;
    forever begin
      @(negedge clk_i);
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          fail_now("spurious_valid");
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("result", result, e);
          chk("valid_cycle", cyc, ec);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input logic is_mul, input logic both, input logic [1:0] op,
                       input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b);
    int lat, en_exp, en_cnt;
    bit seen;
    @(negedge clk_i);
    mult_en     = is_mul;
    div_en      = !is_mul || both;
    operator    = op;
    signed_mode = sm;
    op_a        = a;
    op_b        = b;
    if (is_mul) begin
      lat = 33; en_exp = 32;
    end else if (b == 32'd0) begin
      lat = 1; en_exp = 0;
    end else begin
      lat = 36; en_exp = 35;
    end
    exp_q.push_back(model(is_mul, op, sm, a, b));
    exp_cyc_q.push_back(cyc + lat);
    en_cnt = 0;
    seen   = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk_i);
      if (valid_o) seen = 1;
      else if (multdiv_en) en_cnt++;
    end
    mult_en = 1'b0;
    div_en  = 1'b0;
    if (!seen) begin
      fail_now("timeout");
      exp_q.delete();
      exp_cyc_q.delete();
    end else begin
      chk("en_cycles", en_cnt, en_exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 255);
      default: return $urandom();
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int vcnt;
    logic [1:0] sm;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_en", multdiv_en, 0);
    chk("rst_opa", alu_operand_a, 0);
    chk("rst_opb", alu_operand_b, 0);
    chk("rst_result", result, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed cases
    do_op(1, 0, 2'd0, 2'b11, 32'd7, 32'd6);
    do_op(1, 0, 2'd1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(1, 0, 2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(1, 0, 2'd1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(0, 0, 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2);
    do_op(0, 0, 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2);
    do_op(0, 0, 2'd2, 2'b00, 32'd100, 32'd7);
    do_op(0, 0, 2'd3, 2'b00, 32'd100, 32'd7);
    do_op(0, 0, 2'd2, 2'b00, 32'd5, 32'd0);
    do_op(0, 0, 2'd3, 2'b11, 32'h1234, 32'd0);
    do_op(0, 0, 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(0, 0, 2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1, 1, 2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000);

    // Abort a divide at cycle 10
    @(negedge clk_i);
    div_en = 1'b1; operator = 2'd2; signed_mode = 2'b11;
    op_a = 32'd1000; op_b = 32'd3;
    repeat (10) @(negedge clk_i);
    chk("abort_en_before", multdiv_en, 1);
    div_en = 1'b0;
    @(negedge clk_i);
    chk("abort_en_after", multdiv_en, 0);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) vcnt++;
    end
    chk("abort_no_valid", vcnt, 0);

    // Reset in the middle of a multiply at cycle 20
    @(negedge clk_i);
    mult_en = 1'b1; operator = 2'd0; signed_mode = 2'b11;
    op_a = 32'd12345; op_b = 32'd678;
    repeat (20) @(negedge clk_i);
    chk("mid_en_before", multdiv_en, 1);
    rst_i = 1'b1;
    mult_en = 1'b0;
    #1;
    chk("mid_rst_en", multdiv_en, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_opa", alu_operand_a, 0);
    chk("mid_rst_result", result, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    do_op(1, 0, 2'd0, 2'b11, 32'd12345, 32'd678);

    // Randomized operations
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0: sm = 2'b00;
          1: sm = 2'b01;
          default: sm = 2'b11;
        endcase
        do_op(1, $urandom_range(0, 3) == 0, {1'b0, 1'($urandom_range(0, 1))}, sm, pick(), pick());
      end else begin
        sm = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        do_op(0, 0, {1'b1, 1'($urandom_range(0, 1))}, sm, pick(), pick());
      end
    end

    repeat (3) @(negedge clk_i);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
